// File: rtl/drbg_keystream_pkg.sv
// drbg_keystream_pkg: shared constants, FSM states and slice helper for the DRBG keystream buffer
package drbg_keystream_pkg;
   localparam int DRBG_WORD_W = 256;
   typedef enum logic [2:0] {WAIT_INIT, IDLE, REQ, WAIT_LOW, SEED} state_t;
   function automatic int slice_count(input int word_w, input int out_w);
      return word_w / out_w;
   endfunction
endpackage

// File: rtl/keystream_word_fifo.sv
// keystream_word_fifo: synchronous word FIFO with registered head output and flush
import drbg_keystream_pkg::*;
module keystream_word_fifo #(
   parameter int W = DRBG_WORD_W,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [W-1:0]             din_i,
   input  logic                     pop_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  dout_q;
   logic [PW-1:0] wr_q, rd_q, rd_d;
   logic [LW-1:0] cnt_q;
   logic          do_push, do_pop, head_from_din;
   assign full_o        = cnt_q == LW'(DEPTH);
   assign do_push       = push_i && !full_o;
   assign do_pop        = pop_i && cnt_q != '0;
   assign rd_d          = do_pop ? rd_q + PW'(1) : rd_q;
   // the pushed word becomes head when the FIFO is empty after this cycle's pop
   assign head_from_din = do_push && cnt_q == LW'(do_pop);
   assign dout_o        = dout_q;
   assign count_o       = cnt_q;
   always_ff @(posedge clk_i) begin
      if (!reset_n_i || flush_i) begin
         wr_q   <= '0;
         rd_q   <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         if (do_push) mem_q[wr_q] <= din_i;
         wr_q   <= wr_q + PW'(do_push);
         rd_q   <= rd_d;
         cnt_q  <= cnt_q + LW'(do_push) - LW'(do_pop);
         dout_q <= head_from_din ? din_i : mem_q[rd_d];
      end
   end
endmodule

// File: rtl/drbg_keystream_buffer.sv
// drbg_keystream_buffer: requests DRBG words, buffers them and serialises keystream slices
module drbg_keystream_buffer
   import drbg_keystream_pkg::*;
#(
   parameter int WORD_W       = DRBG_WORD_W,
   parameter int OUT_W        = 32,
   parameter int DEPTH        = 4,
   parameter int RESEED_WORDS = 1024
) (
   input  logic                     clk_i,
   input  logic                     reset_n_i,
   input  logic                     flush_i,
   input  logic                     drbg_init_ready_i,
   output logic                     drbg_next_bits_o,
   input  logic                     drbg_next_bits_ready_i,
   input  logic [WORD_W-1:0]        drbg_random_bits_i,
   output logic                     drbg_next_seed_o,
   output logic                     ks_valid_o,
   input  logic                     ks_ready_i,
   output logic [OUT_W-1:0]         ks_data_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic [31:0]              words_since_seed_o,
   output logic                     overflow_err_o
);
   localparam int SLICES = slice_count(WORD_W, OUT_W);
   localparam int SW     = SLICES > 1 ? $clog2(SLICES) : 1;
   localparam int LW     = $clog2(DEPTH) + 1;
   if (WORD_W % OUT_W != 0) begin : g_width_check
      $error("WORD_W must be a multiple of OUT_W");
   end
   state_t         state_q;
   logic           rdy_q, drop_q, err_q, next_bits_q, next_seed_q;
   logic [31:0]    wss_q;
   logic [SW-1:0]  slice_q, slice_d;
   logic [WORD_W-1:0] head;
   logic           full, rise, push, fire, last;
   assign rise    = drbg_next_bits_ready_i && !rdy_q;
   assign push    = state_q == REQ && rise && !drop_q && !flush_i;
   assign fire    = ks_valid_o && ks_ready_i;
   assign last    = slice_q == SW'(SLICES - 1);
   assign slice_d = flush_i ? '0 : fire ? (last ? '0 : slice_q + SW'(1)) : slice_q;
   assign ks_valid_o         = level_o != '0;
   assign ks_data_o          = head[int'(slice_q) * OUT_W +: OUT_W];
   assign drbg_next_bits_o   = next_bits_q;
   assign drbg_next_seed_o   = next_seed_q;
   assign words_since_seed_o = wss_q;
   assign overflow_err_o     = err_q;
   keystream_word_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .flush_i   (flush_i),
      .push_i    (push),
      .din_i     (drbg_random_bits_i),
      .pop_i     (fire && last),
      .dout_o    (head),
      .count_o   (level_o),
      .full_o    (full)
   );
   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state_q     <= WAIT_INIT;
         rdy_q       <= 1'b0;
         drop_q      <= 1'b0;
         err_q       <= 1'b0;
         next_bits_q <= 1'b0;
         next_seed_q <= 1'b0;
         wss_q       <= '0;
         slice_q     <= '0;
      end else begin
         rdy_q       <= drbg_next_bits_ready_i;
         next_seed_q <= 1'b0;
         slice_q     <= slice_d;
         if (rise && (state_q != REQ || full)) err_q <= 1'b1;
         case (state_q)
            WAIT_INIT: if (drbg_init_ready_i) state_q <= IDLE;
            // only IDLE can start a request, so nothing is outstanding here
            IDLE: if (level_o < LW'(DEPTH)) begin
               state_q     <= REQ;
               next_bits_q <= 1'b1;
            end
            REQ: if (rise) begin
               wss_q       <= wss_q + 32'(wss_q != '1);
               next_bits_q <= 1'b0;
               drop_q      <= 1'b0;
               state_q     <= WAIT_LOW;
            end else if (flush_i) drop_q <= 1'b1;
            WAIT_LOW: if (!drbg_next_bits_ready_i) begin
               if (RESEED_WORDS != 0 && wss_q == 32'(RESEED_WORDS)) begin
                  state_q     <= SEED;
                  next_seed_q <= 1'b1;
               end else state_q <= IDLE;
            end
            SEED: begin
               wss_q   <= '0;
               state_q <= WAIT_INIT;
            end
            default: state_q <= WAIT_INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_drbg_keystream_buffer.sv
// tb_drbg_keystream_buffer: directed self-checking bench driving a scripted DRBG and consumer
module tb_drbg_keystream_buffer;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         flush = 1'b0;
   logic         init_ready = 1'b0;
   logic         next_bits;
   logic         nb_ready = 1'b0;
   logic [255:0] rbits = '0;
   logic         next_seed;
   logic         ks_valid;
   logic         ks_ready = 1'b0;
   logic [31:0]  ks_data;
   logic [2:0]   level;
   logic [31:0]  wss;
   logic         ovf;
   int checks = 0;
   int errors = 0;
   logic [255:0] w1, w2, w3, w4, w5, wp, wq, wx, wy;

   always #5 clk = ~clk;

   drbg_keystream_buffer #(.WORD_W(256), .OUT_W(32), .DEPTH(4), .RESEED_WORDS(3)) dut (
      .clk_i                  (clk),
      .reset_n_i              (reset_n),
      .flush_i                (flush),
      .drbg_init_ready_i      (init_ready),
      .drbg_next_bits_o       (next_bits),
      .drbg_next_bits_ready_i (nb_ready),
      .drbg_random_bits_i     (rbits),
      .drbg_next_seed_o       (next_seed),
      .ks_valid_o             (ks_valid),
      .ks_ready_i             (ks_ready),
      .ks_data_o              (ks_data),
      .level_o                (level),
      .words_since_seed_o     (wss),
      .overflow_err_o         (ovf)
   );

   function automatic logic [255:0] mkw(input logic [7:0] b);
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[i*32 +: 32] = {b, 16'hA5A5, 8'(i)};
      return w;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic give(input logic [255:0] w);
      int n = 0;
      while (!next_bits && n < 50) begin
         tick();
         n++;
      end
      chk("req_seen", next_bits, 1);
      rbits    = w;
      nb_ready = 1'b1;
      tick();
      nb_ready = 1'b0;
   endtask

   initial begin
      w1 = mkw(8'h01); w2 = mkw(8'h02); w3 = mkw(8'h03); w4 = mkw(8'h04); w5 = mkw(8'h05);
      wp = mkw(8'h10); wq = mkw(8'h11); wx = mkw(8'h12); wy = mkw(8'h13);
      // test 1: reset state, init handshake, first capture
      tick();
      tick();
      chk("rst_next_bits", next_bits, 0);
      chk("rst_ks_valid", ks_valid, 0);
      chk("rst_level", level, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_next_seed", next_seed, 0);
      reset_n = 1'b1;
      repeat (7) tick();
      chk("no_req_before_init", next_bits, 0);
      init_ready = 1'b1;
      tick();
      chk("init_plus1_no_req", next_bits, 0);
      tick();
      chk("init_plus2_req", next_bits, 1);
      give(w1);
      chk("t1_ks_valid", ks_valid, 1);
      chk("t1_ks_data", ks_data, w1[31:0]);
      chk("t1_level", level, 1);
      chk("t1_wss", wss, 1);
      chk("t1_req_dropped", next_bits, 0);
      // test 2: drain one word as 8 slices, LSB first
      ks_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk("t2_valid", ks_valid, 1);
         chk("t2_slice", ks_data, w1[i*32 +: 32]);
         tick();
      end
      chk("t2_empty_valid", ks_valid, 0);
      chk("t2_empty_level", level, 0);
      // test 3: fill FIFO with consumer stalled
      ks_ready = 1'b0;
      give(w2);
      give(w3);
      give(w4);
      give(w5);
      repeat (5) tick();
      chk("t3_level_full", level, 4);
      chk("t3_no_req_full", next_bits, 0);
      chk("t3_ovf", ovf, 0);
      chk("t3_head", ks_data, w2[31:0]);
      tick();
      chk("t3_stall_stable", ks_data, w2[31:0]);
      ks_ready = 1'b1;
      repeat (8) tick();
      ks_ready = 1'b0;
      chk("t3_level_after_pop", level, 3);
      chk("t3_next_head", ks_data, w3[31:0]);
      chk("t3_req_not_yet", next_bits, 0);
      tick();
      chk("t3_req_after_pop", next_bits, 1);
      // test 4: reseed after 3 captures
      do_reset();
      chk("t4_rst_wss", wss, 0);
      give(w1);
      give(w2);
      give(w3);
      chk("t4_wss3", wss, 3);
      init_ready = 1'b0;
      tick();
      chk("t4_seed_pulse", next_seed, 1);
      tick();
      chk("t4_seed_one_cycle", next_seed, 0);
      chk("t4_wss_cleared", wss, 0);
      repeat (5) tick();
      chk("t4_no_req_wait_init", next_bits, 0);
      init_ready = 1'b1;
      tick();
      tick();
      chk("t4_req_after_init", next_bits, 1);
      // test 5: flush during REQ with 2 words buffered
      do_reset();
      give(wp);
      give(wq);
      chk("t5_level2", level, 2);
      tick();
      tick();
      chk("t5_in_req", next_bits, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("t5_flush_level", level, 0);
      chk("t5_flush_valid", ks_valid, 0);
      chk("t5_still_req", next_bits, 1);
      chk("t5_wss_kept", wss, 2);
      give(wx);
      chk("t5_inflight_dropped", level, 0);
      chk("t5_no_ovf", ovf, 0);
      give(wy);
      chk("t5_next_valid", ks_valid, 1);
      chk("t5_next_slice", ks_data, wy[31:0]);
      // test 6: spurious ready edge in IDLE
      give(w3);
      give(w4);
      give(w5);
      chk("t6_full", level, 4);
      tick();
      tick();
      chk("t6_idle_no_req", next_bits, 0);
      rbits    = w1;
      nb_ready = 1'b1;
      tick();
      nb_ready = 1'b0;
      chk("t6_ovf_set", ovf, 1);
      chk("t6_word_dropped", level, 4);
      chk("t6_head_kept", ks_data, wy[31:0]);
      repeat (4) tick();
      chk("t6_ovf_sticky", ovf, 1);
      reset_n = 1'b0;
      tick();
      chk("t6_ovf_cleared", ovf, 0);
      chk("t6_rst_level", level, 0);
      reset_n = 1'b1;
      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
